fb_arbiter: RTL and testbench

//   Shares a single-port framebuffer RAM between the VGA display reader and NUM_WR Mandelbrot compute engines.

---
 rtl/fb_arbiter_pkg.sv | 37 +++
 rtl/fb_arbiter_rr.sv | 60 ++++++
 rtl/fb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_fb_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : fb_arbiter_pkg                                                |
// | Purpose  : VGA timing constants, framebuffer defaults and the slot type  |
// |            shared by the framebuffer arbiter and its round-robin core.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package fb_arbiter_pkg;

  // 640x480@60 timing as produced by the vga timing generator
  localparam int c_h_act_start = 144;
  localparam int c_v_act_start = 31;
  localparam int c_h_act       = 640;
  localparam int c_v_act       = 480;
  localparam int c_h_total     = 800;
  localparam int c_v_total     = 521;

  // Framebuffer is half resolution in both axes and upscaled 2x on display
  localparam int c_fb_w        = 320;
  localparam int c_fb_h        = 240;
  localparam int c_addr_w      = $clog2(c_fb_w * c_fb_h);

  // What the RAM port does in the cycle after a slot is decoded
  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,   // write slot with no requester
    SLOT_READ  = 2'd1,   // display fetch
    SLOT_WRITE = 2'd2,   // granted in-range write
    SLOT_DROP  = 2'd3    // granted write with out-of-range address, discarded
  } slot_e;

  // Width of a pointer that can index n requesters (at least one bit)
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fb_arbiter_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : rr_arbiter                                                    |
// | Purpose  : Round-robin grant among NUM_WR requesters. Grant is           |
// |            combinational; the search pointer moves past the winner.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module rr_arbiter
  import fb_arbiter_pkg::*;
#(
  parameter  int NUM_WR = 4,
  localparam int PTR_W  = ptr_width(NUM_WR)
) (
  input  logic              vga_clk,
  input  logic              rst,
  input  logic [NUM_WR-1:0] req,
  input  logic              enable,
  output logic [NUM_WR-1:0] gnt,
  output logic              gnt_any,
  output logic [PTR_W-1:0]  gnt_idx
);

  logic [PTR_W-1:0] r_ptr;
  logic             w_found;
  logic [PTR_W-1:0] w_idx;
  int               w_pos;

  // Find the first active request at or after the pointer, wrapping around
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_pos   = 0;
    for (int k = 0; k < NUM_WR; k++) begin
      w_pos = (int'(r_ptr) + k) % NUM_WR;
      if (!w_found && req[w_pos]) begin
        w_found = 1'b1;
        w_idx   = PTR_W'(w_pos);
      end
    end
  end

  // One-hot grant, only when the slot belongs to the writers
  always_comb begin
    gnt     = '0;
    gnt_any = enable && w_found;
    gnt_idx = w_idx;
    if (gnt_any) gnt[w_idx] = 1'b1;
  end

  // Pointer moves to the requester after the winner; holds when idle
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (gnt_any) begin
      r_ptr <= (w_idx == PTR_W'(NUM_WR - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fb_arbiter                                                    |
// | Purpose  : Shares a single-port framebuffer RAM between the VGA reader   |
// |            (even active pixel slots) and NUM_WR compute engines (all     |
// |            other slots), and emits the 2x-upscaled pixel stream plus a   |
// |            per-frame start tick.                                         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module fb_arbiter
  import fb_arbiter_pkg::*;
#(
  parameter int NUM_WR      = 4,
  parameter int DATA_W      = 8,
  parameter int FB_W        = c_fb_w,
  parameter int FB_H        = c_fb_h,
  parameter int ADDR_W      = c_addr_w,
  parameter int H_ACT_START = c_h_act_start,
  parameter int V_ACT_START = c_v_act_start,
  parameter int H_ACT       = c_h_act,
  parameter int V_ACT       = c_v_act
) (
  input  logic                     vga_clk,
  input  logic                     rst,
  input  logic [9:0]               hcount,
  input  logic [9:0]               vcount,
  input  logic [NUM_WR-1:0]        wr_req,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic [NUM_WR-1:0]        wr_gnt,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [DATA_W-1:0]        pix_data,
  output logic                     pix_valid,
  output logic                     frame_tick,
  output logic                     err_oob
);

  localparam int         PTR_W     = ptr_width(NUM_WR);
  localparam int         c_aw1     = ADDR_W + 1;
  localparam logic [9:0] c_h_lo    = 10'(H_ACT_START);
  localparam logic [9:0] c_h_hi    = 10'(H_ACT_START + H_ACT);
  localparam logic [9:0] c_v_lo    = 10'(V_ACT_START);
  localparam logic [9:0] c_v_hi    = 10'(V_ACT_START + V_ACT);
  // Compare one bit wider so a framebuffer filling the whole address space works
  localparam logic [ADDR_W:0] c_fb_size = c_aw1'(FB_W * FB_H);

  // The framebuffer must be addressable with ADDR_W bits
  generate
    if ($clog2(FB_W * FB_H) > ADDR_W) begin : g_addr_check
      $error("fb_arbiter: ADDR_W too small for FB_W*FB_H");
    end
  endgenerate

  logic [9:0]        w_hrel;
  logic [9:0]        w_vrel;
  logic              w_active;
  logic              w_disp;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_gnt_any;
  logic [PTR_W-1:0]  w_gnt_idx;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_oob;
  slot_e             w_slot;
  logic              r_act1, r_rd1, r_act2, r_rd2;

  // Position decode: active window and the display (even-pixel) slot
  always_comb begin
    w_hrel    = hcount - c_h_lo;
    w_vrel    = vcount - c_v_lo;
    w_active  = (hcount >= c_h_lo) && (hcount < c_h_hi) &&
                (vcount >= c_v_lo) && (vcount < c_v_hi);
    w_disp    = w_active && !w_hrel[0];
    w_rd_addr = ADDR_W'(w_vrel >> 1) * ADDR_W'(FB_W) + ADDR_W'(w_hrel >> 1);
  end

  // Writers only see grants outside display slots and outside reset
  rr_arbiter #(
    .NUM_WR (NUM_WR)
  ) u_rr (
    .vga_clk (vga_clk),
    .rst     (rst),
    .req     (wr_req),
    .enable  (!w_disp && !rst),
    .gnt     (wr_gnt),
    .gnt_any (w_gnt_any),
    .gnt_idx (w_gnt_idx)
  );

  // Pick the winning writer's address/data and classify the slot
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (PTR_W'(i) == w_gnt_idx) begin
        w_sel_addr = wr_addr[i*ADDR_W +: ADDR_W];
        w_sel_data = wr_data[i*DATA_W +: DATA_W];
      end
    end
    w_oob = ({1'b0, w_sel_addr} >= c_fb_size);
    if (w_disp)         w_slot = SLOT_READ;
    else if (!w_gnt_any) w_slot = SLOT_IDLE;
    else if (w_oob)      w_slot = SLOT_DROP;
    else                 w_slot = SLOT_WRITE;
  end

  // RAM command register: one access per slot, issued the following cycle
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (w_slot)
        SLOT_READ: begin
          mem_en   <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= w_rd_addr;
        end
        SLOT_WRITE: begin
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= w_sel_addr;
          mem_wdata <= w_sel_data;
        end
        default: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Sticky out-of-range write flag
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst)                      err_oob <= 1'b0;
    else if (w_slot == SLOT_DROP) err_oob <= 1'b1;
  end

  // Track each sampled position through the RAM read latency
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      r_act1 <= 1'b0;
      r_rd1  <= 1'b0;
      r_act2 <= 1'b0;
      r_rd2  <= 1'b0;
    end else begin
      r_act1 <= w_active;
      r_rd1  <= w_disp;
      r_act2 <= r_act1;
      r_rd2  <= r_rd1;
    end
  end

  // Pixel register: load on even reads, hold on odd pixels, clear in blanking
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      pix_data  <= '0;
      pix_valid <= 1'b0;
    end else begin
      pix_valid <= r_act2;
      if (!r_act2)    pix_data <= '0;
      else if (r_rd2) pix_data <= mem_rdata;
    end
  end

  // Frame tick at the first cycle of vertical blank
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) frame_tick <= 1'b0;
    else     frame_tick <= (hcount == 10'd0) && (vcount == c_v_hi);
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fb_arbiter                                                 |
// | Purpose  : Self-checking bench for fb_arbiter with a RAM model and a     |
// |            behavioural reference for slots, grants and pixels.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fb_arbiter;

  localparam int NUM_WR  = 4;
  localparam int DATA_W  = 8;
  localparam int FB_W    = 320;
  localparam int FB_H    = 240;
  localparam int ADDR_W  = 17;
  localparam int HS      = 144;
  localparam int VS      = 31;
  localparam int HA      = 640;
  localparam int VA      = 480;
  localparam int FB_SIZE = FB_W * FB_H;

  logic                     vga_clk = 1'b0;
  logic                     rst     = 1'b0;
  logic [9:0]               hcount  = '0;
  logic [9:0]               vcount  = '0;
  logic [NUM_WR-1:0]        wr_req  = '0;
  logic [NUM_WR*ADDR_W-1:0] wr_addr = '0;
  logic [NUM_WR*DATA_W-1:0] wr_data = '0;
  logic [NUM_WR-1:0]        wr_gnt;
  logic                     mem_en, mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_wdata;
  logic [DATA_W-1:0]        mem_rdata = '0;
  logic [DATA_W-1:0]        pix_data;
  logic                     pix_valid, frame_tick, err_oob;

  int total = 0;
  int bad   = 0;
  int model_ptr = 0;
  logic [DATA_W-1:0] ram [0:FB_SIZE-1];

  fb_arbiter dut (
    .vga_clk (vga_clk), .rst (rst), .hcount (hcount), .vcount (vcount),
    .wr_req (wr_req), .wr_addr (wr_addr), .wr_data (wr_data), .wr_gnt (wr_gnt),
    .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata), .pix_data (pix_data), .pix_valid (pix_valid),
    .frame_tick (frame_tick), .err_oob (err_oob)
  );

  always #5 vga_clk = ~vga_clk;

  // Synchronous single-port RAM, one cycle read latency
  always @(posedge vga_clk) begin
    if (mem_en === 1'b1 && int'(mem_addr) < FB_SIZE) begin
      if (mem_we) ram[int'(mem_addr)] <= mem_wdata;
      else        mem_rdata <= ram[int'(mem_addr)];
    end
  end

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic do_reset();
    wr_req = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic set_writer(input int i, input int addr, input int data);
    wr_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    wr_data[i*DATA_W +: DATA_W] = DATA_W'(data);
  endtask

  function automatic bit is_active(input int h, input int v);
    return (h >= HS) && (h < HS + HA) && (v >= VS) && (v < VS + VA);
  endfunction

  function automatic bit is_disp(input int h, input int v);
    return is_active(h, v) && (((h - HS) % 2) == 0);
  endfunction

  function automatic int fb_addr(input int h, input int v);
    return ((v - VS) / 2) * FB_W + (h - HS) / 2;
  endfunction

  // Winner is the first requester met walking upward from the pointer
  function automatic int rr_pick(input logic [NUM_WR-1:0] req, input int ptr);
    for (int k = 0; k < NUM_WR; k++)
      if (req[(ptr + k) % NUM_WR]) return (ptr + k) % NUM_WR;
    return -1;
  endfunction

  task automatic test_reset();
    hcount = 10'd300; vcount = 10'd100;
    for (int i = 0; i < NUM_WR; i++) set_writer(i, i * 10 + 5, 8'h40 + i);
    wr_req = '1;
    repeat (6) tick();
    rst = 1'b1;
    #1;
    total++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      bad++;
      $display("FAIL reset_mem got en=%b we=%b addr=%0d wdata=%h want all 0", mem_en, mem_we, mem_addr, mem_wdata);
    end
    total++;
    if (pix_valid !== 1'b0 || pix_data !== '0 || frame_tick !== 1'b0 || err_oob !== 1'b0) begin
      bad++;
      $display("FAIL reset_out got valid=%b pix=%h tick=%b oob=%b want all 0", pix_valid, pix_data, frame_tick, err_oob);
    end
    total++;
    if (wr_gnt !== '0) begin
      bad++;
      $display("FAIL reset_gnt got %b want 0000", wr_gnt);
    end
    hcount = 10'd10; vcount = 10'd0;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (wr_gnt !== 4'b0001) begin
      bad++;
      $display("FAIL reset_first_gnt got %b want 0001", wr_gnt);
    end
    tick();
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 17'd5 || mem_wdata !== 8'h40) begin
      bad++;
      $display("FAIL reset_first_write got en=%b we=%b addr=%0d data=%h want 1 1 5 40", mem_en, mem_we, mem_addr, mem_wdata);
    end
    wr_req = '0;
  endtask

  task automatic test_slot_split();
    do_reset();
    hcount = 10'd144; vcount = 10'd31;
    set_writer(2, 100, 8'h33);
    wr_req = 4'b0100;
    #1;
    total++;
    if (wr_gnt !== 4'b0000) begin
      bad++; $display("FAIL split_disp_gnt got %b want 0000", wr_gnt);
    end
    tick();
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'd0) begin
      bad++; $display("FAIL split_read0 got en=%b we=%b addr=%0d want 1 0 0", mem_en, mem_we, mem_addr);
    end
    hcount = 10'd145;
    #1;
    total++;
    if (wr_gnt !== 4'b0100) begin
      bad++; $display("FAIL split_wr_gnt got %b want 0100", wr_gnt);
    end
    tick();
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 17'd100 || mem_wdata !== 8'h33) begin
      bad++; $display("FAIL split_write got en=%b we=%b addr=%0d data=%h want 1 1 100 33", mem_en, mem_we, mem_addr, mem_wdata);
    end
    wr_req = '0;
    hcount = 10'd146;
    #1;
    tick();
    total++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'd1) begin
      bad++; $display("FAIL split_read1 got en=%b we=%b addr=%0d want 1 0 1", mem_en, mem_we, mem_addr);
    end
  endtask

  task automatic test_round_robin();
    logic [NUM_WR-1:0] pats [2];
    logic [NUM_WR-1:0] exp_gnt;
    int p;
    pats[0] = 4'b1111;
    pats[1] = 4'b1101;
    for (int s = 0; s < 2; s++) begin
      do_reset();
      hcount = 10'd0; vcount = 10'd0;
      for (int i = 0; i < NUM_WR; i++) set_writer(i, 1000 + i, 8'h10 + i);
      wr_req = pats[s];
      for (int c = 0; c < 6; c++) begin
        #1;
        p = rr_pick(wr_req, model_ptr);
        exp_gnt = '0;
        exp_gnt[p] = 1'b1;
        total++;
        if (wr_gnt !== exp_gnt) begin
          bad++; $display("FAIL rr_gnt pat=%b cyc=%0d got %b want %b", pats[s], c, wr_gnt, exp_gnt);
        end
        tick();
        total++;
        if (mem_we !== 1'b1 || int'(mem_addr) != 1000 + p) begin
          bad++; $display("FAIL rr_write pat=%b cyc=%0d got we=%b addr=%0d want 1 %0d", pats[s], c, mem_we, mem_addr, 1000 + p);
        end
        model_ptr = (p + 1) % NUM_WR;
      end
    end
    wr_req = '0;
  endtask

  task automatic test_random();
    bit                pend  [NUM_WR];
    int                paddr [NUM_WR];
    int                pdata [NUM_WR];
    int                h, v, p;
    bit                d;
    logic [NUM_WR-1:0] exp_gnt;
    do_reset();
    for (int i = 0; i < NUM_WR; i++) pend[i] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          paddr[i] = $urandom_range(0, FB_SIZE - 1);
          pdata[i] = $urandom_range(0, 255);
        end
        wr_req[i] = pend[i];
        set_writer(i, paddr[i], pdata[i]);
      end
      h = $urandom_range(0, 799);
      v = ($urandom_range(0, 1) == 1) ? $urandom_range(VS, VS + VA - 1) : $urandom_range(0, 520);
      hcount = 10'(h); vcount = 10'(v);
      #1;
      d = is_disp(h, v);
      p = d ? -1 : rr_pick(wr_req, model_ptr);
      exp_gnt = '0;
      if (p >= 0) exp_gnt[p] = 1'b1;
      total++;
      if (wr_gnt !== exp_gnt) begin
        bad++; $display("FAIL rand_gnt cyc=%0d h=%0d v=%0d got %b want %b", c, h, v, wr_gnt, exp_gnt);
      end
      tick();
      total++;
      if (d) begin
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || int'(mem_addr) != fb_addr(h, v)) begin
          bad++; $display("FAIL rand_read cyc=%0d got en=%b we=%b addr=%0d want 1 0 %0d", c, mem_en, mem_we, mem_addr, fb_addr(h, v));
        end
      end else if (p >= 0) begin
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || int'(mem_addr) != paddr[p] || int'(mem_wdata) != pdata[p]) begin
          bad++; $display("FAIL rand_write cyc=%0d got en=%b we=%b addr=%0d data=%h want 1 1 %0d %h", c, mem_en, mem_we, mem_addr, mem_wdata, paddr[p], pdata[p]);
        end
        pend[p] = 1'b0;
        model_ptr = (p + 1) % NUM_WR;
      end else begin
        if (mem_en !== 1'b0) begin
          bad++; $display("FAIL rand_idle cyc=%0d got en=%b want 0", c, mem_en);
        end
      end
    end
    wr_req = '0;
  endtask

  task automatic test_pixel_latency();
    do_reset();
    ram[320] = 8'h11;
    ram[321] = 8'h5A;
    ram[322] = 8'hC3;
    vcount = 10'd33;
    for (int k = 0; k < 12; k++) begin
      hcount = 10'(140 + k);
      tick();
      if (k == 8 || k == 9) begin
        total++;
        if (pix_valid !== 1'b1 || pix_data !== 8'h5A) begin
          bad++; $display("FAIL pix_latency k=%0d got valid=%b pix=%h want 1 5a", k, pix_valid, pix_data);
        end
      end
      if (k == 10) begin
        total++;
        if (pix_valid !== 1'b1 || pix_data !== 8'hC3) begin
          bad++; $display("FAIL pix_next k=%0d got valid=%b pix=%h want 1 c3", k, pix_valid, pix_data);
        end
      end
    end
  endtask

  task automatic test_pixel_sweep();
    int          lines [6];
    bit          q_val [$];
    logic [7:0]  q_pix [$];
    bit          ev;
    logic [7:0]  ep;
    lines = '{30, 31, 32, 200, 510, 511};
    do_reset();
    for (int a = 0; a < FB_SIZE; a += 97) ram[a] = 8'($urandom);
    for (int l = 0; l < 6; l++) begin
      q_val.delete();
      q_pix.delete();
      vcount = 10'(lines[l]);
      for (int h = 130; h < 795; h++) begin
        hcount = 10'(h);
        q_val.push_back(is_active(h, lines[l]));
        q_pix.push_back(is_active(h, lines[l]) ? ram[fb_addr(h, lines[l])] : 8'h00);
        tick();
        if (q_val.size() == 3) begin
          ev = q_val.pop_front();
          ep = q_pix.pop_front();
          total++;
          if (pix_valid !== ev || pix_data !== ep) begin
            bad++; $display("FAIL pix_sweep v=%0d h=%0d got valid=%b pix=%h want %b %h", lines[l], h - 2, pix_valid, pix_data, ev, ep);
          end
        end
      end
    end
  endtask

  task automatic test_oob();
    do_reset();
    hcount = 10'd0; vcount = 10'd0;
    set_writer(0, FB_SIZE - 1, 8'h11);
    wr_req = 4'b0001;
    #1;
    total++;
    if (wr_gnt !== 4'b0001) begin
      bad++; $display("FAIL oob_edge_gnt got %b want 0001", wr_gnt);
    end
    tick();
    total++;
    if (mem_en !== 1'b1 || int'(mem_addr) != FB_SIZE - 1 || err_oob !== 1'b0) begin
      bad++; $display("FAIL oob_edge_write got en=%b addr=%0d oob=%b want 1 %0d 0", mem_en, mem_addr, err_oob, FB_SIZE - 1);
    end
    set_writer(0, FB_SIZE, 8'hAA);
    #1;
    total++;
    if (wr_gnt !== 4'b0001) begin
      bad++; $display("FAIL oob_gnt got %b want 0001", wr_gnt);
    end
    tick();
    total++;
    if (mem_en !== 1'b0 || err_oob !== 1'b1) begin
      bad++; $display("FAIL oob_drop got en=%b oob=%b want 0 1", mem_en, err_oob);
    end
    wr_req = 4'b0010;
    set_writer(1, 50, 8'h22);
    repeat (4) tick();
    total++;
    if (err_oob !== 1'b1) begin
      bad++; $display("FAIL oob_sticky got %b want 1", err_oob);
    end
    wr_req = '0;
    rst = 1'b1;
    #1;
    total++;
    if (err_oob !== 1'b0) begin
      bad++; $display("FAIL oob_clear got %b want 0", err_oob);
    end
    tick();
    rst = 1'b0;
  endtask

  // Two windows around the start of vertical blank, one per frame
  task automatic test_frame_tick();
    int  h, v, pulses;
    bit  prev_hit;
    do_reset();
    pulses = 0;
    for (int f = 0; f < 2; f++) begin
      h = 0; v = 509;
      for (int c = 0; c < 2500; c++) begin
        hcount = 10'(h); vcount = 10'(v);
        prev_hit = (h == 0) && (v == VS + VA);
        tick();
        total++;
        if (frame_tick !== prev_hit) begin
          bad++; $display("FAIL frame_tick f=%0d c=%0d got %b want %b", f, c, frame_tick, prev_hit);
        end
        if (frame_tick === 1'b1) pulses++;
        h++;
        if (h == 800) begin h = 0; v = (v + 1) % 521; end
      end
    end
    total++;
    if (pulses != 2) begin
      bad++; $display("FAIL frame_tick_count got %0d want 2", pulses);
    end
  endtask

  initial begin
    for (int a = 0; a < FB_SIZE; a++) ram[a] = 8'($urandom);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    test_reset();
    test_slot_split();
    test_round_robin();
    test_random();
    test_pixel_latency();
    test_pixel_sweep();
    test_oob();
    test_frame_tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
